uart_duplex_core: RTL

Parametrised full-duplex UART engine, successor to the fixed 8-bit, fixed-baud TX/RX pairing in the board top.
- Generalised in data width, bit period, stop-bit count and runtime parity mode.
- Adds a valid/ready transmit handshake and a receive valid strobe with per-frame error flags.
- Sits between the board top (switches, HEX decoders) and the serial pins.

---
 rtl/uart_duplex_core.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_duplex_core.sv
// Full-duplex UART: TX takes one word per valid/ready handshake (tx_ready low for the whole frame), RX emits a one-cycle valid with error flags.
// Optional internal TX->RX loopback (tx_serial forced high) when UART_LOOPBACK_EN is defined.
module uart_duplex_core #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [1:0]           parity_type,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]          tx_bit_q, tx_bit_d;
  logic                   tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_en_q, tx_par_en_d;
  logic                   tx_par_bit_q, tx_par_bit_d;
  logic                   tx_line, tx_tick;

  state_e                 rx_state_q, rx_state_d;
  logic [1:0]             rx_sync_q;
  logic                   rx_prev_q;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]          rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_en_q, rx_par_en_d;
  logic                   rx_odd_q, rx_odd_d;
  logic                   rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_in, rx_s, rx_tick;

`ifdef UART_LOOPBACK_EN
  assign tx_serial = loopback ? 1'b1 : tx_line;
  assign rx_in     = loopback ? tx_line : rx_serial;
`else
  assign tx_serial = tx_line;
  assign rx_in     = rx_serial;
`endif

  assign tx_ready      = (tx_state_q == S_IDLE);
  assign tx_active     = (tx_state_q != S_IDLE);
  assign rx_active     = (rx_state_q != S_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_s          = rx_sync_q[1];

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_stop_d    = tx_stop_q;
    tx_shift_d   = tx_shift_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_line      = 1'b1;
    tx_done      = 1'b0;
    tx_tick      = (tx_cnt_q == CNT_LAST);
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_state_d   = S_START;
          tx_cnt_d     = '0;
          tx_shift_d   = tx_data;
          tx_par_en_d  = (parity_type == 2'b01) || (parity_type == 2'b10);
          tx_par_bit_d = (parity_type == 2'b10) ? ^tx_data : ~^tx_data;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_tick) begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_stop_d  = 1'b0;
          if (tx_bit_q == BIT_LAST) tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_line = tx_par_bit_q;
        if (tx_tick) tx_state_d = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) begin
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = S_IDLE;
            tx_done    = 1'b1;
          end else begin
            tx_stop_d = tx_stop_q + 1'b1;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    rx_par_d    = rx_par_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_perr_d   = 1'b0;
    rx_ferr_d   = 1'b0;
    rx_tick     = (rx_cnt_q == CNT_LAST);
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d  = S_START;
          rx_cnt_d    = '0;
          rx_par_en_d = (parity_type == 2'b01) || (parity_type == 2'b10);
          rx_odd_d    = (parity_type == 2'b01);
        end
      end
      // Half a bit after the edge: a line already back high was a glitch.
      S_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_tick) begin
          rx_par_d   = rx_s;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_state_d = S_IDLE;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_perr_d  = rx_par_en_q && ((^rx_shift_q ^ rx_par_q) != rx_odd_q);
          rx_ferr_d  = !rx_s;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_stop_q    <= 1'b0;
      tx_shift_q   <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      rx_state_q   <= S_IDLE;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_par_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_stop_q    <= tx_stop_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      rx_state_q   <= rx_state_d;
      rx_sync_q    <= {rx_sync_q[0], rx_in};
      rx_prev_q    <= rx_s;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_odd_q     <= rx_odd_d;
      rx_par_q     <= rx_par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

endmodule
